// File: rtl/serial_bus_slave_port.sv
// serial_bus_slave_port: serial bus responder that turns bit streams into single parallel memory accesses
module serial_bus_slave_port #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  swdata,
    input  logic                  smode,
    input  logic                  mvalid,
    output logic                  srdata,
    output logic                  svalid,
    output logic                  sready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wen,
    output logic                  mem_ren,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rvalid
);
    localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW = $clog2(MAXW + 1);

    typedef enum logic [2:0] {IDLE, ADDR, WDATA, MEMWR, MEMRD, RDATA} state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  mode_q, mode_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  sready_q;

    // State and datapath registers; sready is registered so it first rises one edge after reset release
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mode_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            sready_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            sready_q <= (state_d == IDLE);
        end
    end

    // Next-state logic; LSB-first bits enter at the top and shift down so the first bit lands at [0]
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (mvalid) begin
                    addr_d = (addr_q >> 1) | (ADDR_WIDTH'(swdata) << (ADDR_WIDTH - 1));
                    mode_d = smode;
                    if (ADDR_WIDTH == 1) begin
                        state_d = smode ? WDATA : MEMRD;
                        cnt_d   = '0;
                    end else begin
                        state_d = ADDR;
                        cnt_d   = CW'(1);
                    end
                end
            end
            ADDR: begin
                if (mvalid) begin
                    addr_d = (addr_q >> 1) | (ADDR_WIDTH'(swdata) << (ADDR_WIDTH - 1));
                    if (cnt_q == CW'(ADDR_WIDTH - 1)) begin
                        state_d = mode_q ? WDATA : MEMRD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            WDATA: begin
                if (mvalid) begin
                    wdata_d = (wdata_q >> 1) | (DATA_WIDTH'(swdata) << (DATA_WIDTH - 1));
                    if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                        state_d = MEMWR;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            MEMWR: begin
                state_d = IDLE;
            end
            MEMRD: begin
                cnt_d = CW'(1);
                if (mem_rvalid) begin
                    rdata_d = mem_rdata;
                    state_d = RDATA;
                    cnt_d   = '0;
                end
            end
            RDATA: begin
                rdata_d = rdata_q >> 1;
                if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign sready    = sready_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wen   = (state_q == MEMWR);
    assign mem_ren   = (state_q == MEMRD) && (cnt_q == '0);
    assign svalid    = (state_q == RDATA);
    assign srdata    = svalid & rdata_q[0];
endmodule

// File: tb/tb_serial_bus_slave_port.sv
// tb_serial_bus_slave_port: scoreboard bench driving serial transactions against a small memory model
module tb_serial_bus_slave_port;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        swdata = 1'b0;
    logic        smode = 1'b0;
    logic        mvalid = 1'b0;
    logic        srdata, svalid, sready;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_wen, mem_ren;
    logic [7:0]  mem_rdata;
    logic        mem_rvalid;

    int checks = 0;
    int errors = 0;
    int wen_cnt = 0;
    int ren_cnt = 0;
    int rd_lat = 1;
    int rd_wait = 0;
    logic rd_pend = 1'b0;
    logic [7:0] mem [4096];
    logic [19:0] wq[$];
    logic bq[$];

    serial_bus_slave_port #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) dut (
        .clk(clk), .rstn(rstn), .swdata(swdata), .smode(smode), .mvalid(mvalid),
        .srdata(srdata), .svalid(svalid), .sready(sready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_ren(mem_ren),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
    );

    always #5 clk = ~clk;

    assign mem_rdata  = mem[mem_addr];
    assign mem_rvalid = (mem_ren && rd_lat == 0) || (rd_pend && rd_wait == 0);

    // Memory model: writes on strobe, answers reads rd_lat cycles after mem_ren
    always @(posedge clk) begin
        if (mem_wen) mem[mem_addr] <= mem_wdata;
        if (mem_ren) ren_cnt <= ren_cnt + 1;
        if (mem_wen) wen_cnt <= wen_cnt + 1;
        if (mem_ren && rd_lat != 0) begin
            rd_pend <= 1'b1;
            rd_wait <= rd_lat - 1;
        end else if (rd_pend) begin
            if (rd_wait == 0) rd_pend <= 1'b0;
            else rd_wait <= rd_wait - 1;
        end
    end

    task automatic send(input logic [19:0] v, input int n, input logic m, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && i > 0) begin
                mvalid = 1'b0;
                swdata = 1'($urandom);
                smode  = 1'($urandom);
                @(negedge clk);
            end
            mvalid = 1'b1;
            swdata = v[i];
            smode  = (i == 0) ? m : 1'($urandom);
            @(negedge clk);
        end
        mvalid = 1'b0;
        swdata = 1'b0;
        smode  = 1'b0;
    endtask

    task automatic do_write(input logic [11:0] a, input logic [7:0] d, input bit gaps);
        int w0;
        logic [19:0] e;
        w0 = wen_cnt;
        wq.push_back({d, a});
        send({d, a}, 20, 1'b1, gaps);
        e = wq.pop_front();
        checks++; if (mem_wen !== 1'b1) begin errors++; $display("FAIL wr_strobe got=%b exp=1", mem_wen); end
        checks++; if (mem_addr !== e[11:0]) begin errors++; $display("FAIL wr_addr got=%h exp=%h", mem_addr, e[11:0]); end
        checks++; if (mem_wdata !== e[19:12]) begin errors++; $display("FAIL wr_data got=%h exp=%h", mem_wdata, e[19:12]); end
        checks++; if (sready !== 1'b0) begin errors++; $display("FAIL wr_busy got=%b exp=0", sready); end
        @(negedge clk);
        checks++; if (mem_wen !== 1'b0) begin errors++; $display("FAIL wr_one_cycle got=%b exp=0", mem_wen); end
        checks++; if (sready !== 1'b1) begin errors++; $display("FAIL wr_sready got=%b exp=1", sready); end
        checks++; if (wen_cnt !== w0 + 1) begin errors++; $display("FAIL wr_count got=%0d exp=%0d", wen_cnt, w0 + 1); end
    endtask

    task automatic do_read(input logic [11:0] a, input logic [7:0] d, input int lat, input bit noise);
        int r0, w0, k;
        logic b;
        r0 = ren_cnt;
        w0 = wen_cnt;
        rd_lat = lat;
        for (int i = 0; i < 8; i++) bq.push_back(d[i]);
        send({8'h00, a}, 12, 1'b0, 1'b0);
        checks++; if (mem_ren !== 1'b1) begin errors++; $display("FAIL rd_strobe got=%b exp=1", mem_ren); end
        checks++; if (mem_addr !== a) begin errors++; $display("FAIL rd_addr got=%h exp=%h", mem_addr, a); end
        for (k = 0; k < lat + 6; k++) begin
            if (svalid === 1'b1) break;
            @(negedge clk);
        end
        checks++; if (k != lat + 1) begin errors++; $display("FAIL rd_latency got=%0d exp=%0d", k, lat + 1); end
        for (int i = 0; i < 8; i++) begin
            b = bq.pop_front();
            checks++; if (svalid !== 1'b1) begin errors++; $display("FAIL rd_svalid bit%0d got=%b exp=1", i, svalid); end
            checks++; if (srdata !== b) begin errors++; $display("FAIL rd_bit%0d got=%b exp=%b", i, srdata, b); end
            if (noise) begin
                mvalid = 1'($urandom);
                smode  = 1'($urandom);
                swdata = 1'($urandom);
            end
            @(negedge clk);
        end
        mvalid = 1'b0;
        smode  = 1'b0;
        swdata = 1'b0;
        checks++; if (svalid !== 1'b0 || srdata !== 1'b0) begin errors++; $display("FAIL rd_end got=%b%b exp=00", svalid, srdata); end
        checks++; if (sready !== 1'b1) begin errors++; $display("FAIL rd_sready got=%b exp=1", sready); end
        checks++; if (ren_cnt !== r0 + 1 || wen_cnt !== w0) begin errors++; $display("FAIL rd_strobes ren=%0d wen=%0d exp ren=%0d wen=%0d", ren_cnt, wen_cnt, r0 + 1, w0); end
        @(negedge clk);
        checks++; if (sready !== 1'b1) begin errors++; $display("FAIL rd_idle_hold got=%b exp=1", sready); end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if ({sready, svalid, srdata, mem_wen, mem_ren} !== 5'b0) begin errors++; $display("FAIL rst_ctrl got=%b exp=00000", {sready, svalid, srdata, mem_wen, mem_ren}); end
        checks++; if ({mem_addr, mem_wdata} !== 20'h0) begin errors++; $display("FAIL rst_data got=%h exp=0", {mem_addr, mem_wdata}); end
        rstn = 1'b1;
        #1;
        checks++; if (sready !== 1'b0) begin errors++; $display("FAIL rst_release got=%b exp=0", sready); end
        @(negedge clk);
        checks++; if (sready !== 1'b1) begin errors++; $display("FAIL rst_sready got=%b exp=1", sready); end
    endtask

    task automatic test_write();
        do_write(12'h123, 8'hA5, 1'b0);
    endtask

    task automatic test_read();
        do_read(12'h123, 8'hA5, 3, 1'b0);
    endtask

    task automatic test_gaps();
        do_write(12'h7FF, 8'h3C, 1'b1);
    endtask

    task automatic test_reset_mid();
        int w0, r0;
        w0 = wen_cnt;
        r0 = ren_cnt;
        send({8'hFF, 12'hFFF}, 5, 1'b1, 1'b0);
        rstn = 1'b0;
        #1;
        checks++; if ({sready, svalid, srdata, mem_wen, mem_ren} !== 5'b0) begin errors++; $display("FAIL abort_ctrl got=%b exp=00000", {sready, svalid, srdata, mem_wen, mem_ren}); end
        checks++; if (mem_addr !== 12'h0) begin errors++; $display("FAIL abort_addr got=%h exp=000", mem_addr); end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checks++; if (wen_cnt !== w0 || ren_cnt !== r0) begin errors++; $display("FAIL abort_strobes wen=%0d ren=%0d exp %0d %0d", wen_cnt, ren_cnt, w0, r0); end
        do_write(12'h001, 8'h9E, 1'b0);
        do_read(12'h001, 8'h9E, 1, 1'b0);
    endtask

    task automatic test_rdata_ignore();
        do_read(12'h7FF, 8'h3C, 2, 1'b1);
    endtask

    task automatic test_back_to_back();
        do_write(12'h010, 8'h55, 1'b0);
        do_read(12'h010, 8'h55, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_gaps();
        test_reset_mid();
        test_rdata_ignore();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
